// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared requester indices, arbiter state encoding and a
//               one-hot to index helper for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Requester lane indices on req/we/addr/wdata/gnt/done
  localparam int REQ_FETCH = 0;
  localparam int REQ_OPND  = 1;
  localparam int REQ_STACK = 2;
  localparam int NUM_REQ   = 3;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Convert a one-hot requester vector to its lane index (0 when empty)
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[REQ_OPND])  idx = 2'd1;
    if (oh[REQ_STACK]) idx = 2'd2;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : prio_sel
// Description : Combinational three-way fixed-priority selector
//               (stack > operand > fetch) with a force-fetch override.
//               Produces a one-hot winner, all zero when nothing requests.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_sel
  import proc_pkg::*;
(
  input  logic [2:0] req,
  input  logic       force_fetch,
  output logic [2:0] win
);

  // Pick exactly one requester; a starved fetch overrides the fixed order
  always_comb begin
    win = 3'b000;
    if (force_fetch && req[REQ_FETCH]) begin
      win[REQ_FETCH] = 1'b1;
    end else if (req[REQ_STACK]) begin
      win[REQ_STACK] = 1'b1;
    end else if (req[REQ_OPND]) begin
      win[REQ_OPND] = 1'b1;
    end else if (req[REQ_FETCH]) begin
      win[REQ_FETCH] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single byte-wide memory port between fetch,
//               operand and stack requesters. One owner at a time; the grant
//               is held until mem_ready or a timeout, then a one-cycle done
//               pulse is returned to the owner followed by a bus-idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int AW           = 8,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [23:0]     wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      done,
  output logic [7:0]      rdata,
  output logic            err,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic            mem_ready,
  input  logic [7:0]      mem_rdata
);

  // Counter widths: the timeout counter never exceeds TIMEOUT-1
  localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TCW-1:0] C_TCNT_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] C_STARVE_MAX = SCW'(STARVE_LIMIT);

  arb_state_t      r_state;
  logic [1:0]      r_owner;
  logic [2:0]      r_gnt;
  logic [2:0]      r_done;
  logic [7:0]      r_rdata;
  logic            r_err;
  logic            r_busy;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [7:0]      r_mem_wdata;
  logic [TCW-1:0]  r_tcnt;
  logic [SCW-1:0]  r_starve;

  logic            w_force_fetch;
  logic [2:0]      w_win;
  logic [1:0]      w_win_idx;
  logic            w_arb;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [7:0]      w_sel_wdata;

  // Fetch is forced to win once it has lost STARVE_LIMIT arbitrations in a row
  assign w_force_fetch = (r_starve == C_STARVE_MAX) && req[REQ_FETCH];
  assign w_arb         = (r_state == IDLE) && (req != 3'b000);
  assign w_win_idx     = onehot_to_idx(w_win);

  prio_sel u_prio_sel (
    .req         (req),
    .force_fetch (w_force_fetch),
    .win         (w_win)
  );

  // Route the winning requester's lanes toward the memory port registers
  always_comb begin
    w_sel_we    = we[REQ_FETCH];
    w_sel_addr  = addr[0 +: AW];
    w_sel_wdata = wdata[0 +: 8];
    case (w_win_idx)
      2'd1: begin
        w_sel_we    = we[REQ_OPND];
        w_sel_addr  = addr[AW +: AW];
        w_sel_wdata = wdata[8 +: 8];
      end
      2'd2: begin
        w_sel_we    = we[REQ_STACK];
        w_sel_addr  = addr[2*AW +: AW];
        w_sel_wdata = wdata[16 +: 8];
      end
      default: ;
    endcase
  end

  // Starvation tracking: count fetch losses, clear on a fetch grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_arb) begin
      if (w_win[REQ_FETCH]) begin
        r_starve <= '0;
      end else if (req[REQ_FETCH] && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant, memory strobe and completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= 2'd0;
      r_gnt       <= 3'b000;
      r_done      <= 3'b000;
      r_rdata     <= 8'h00;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb) begin
            r_owner     <= w_win_idx;
            r_gnt       <= w_win;
            r_busy      <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_tcnt      <= '0;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_ready takes precedence over a timeout on the same edge
          if (mem_ready) begin
            r_rdata  <= mem_rdata;
            r_done   <= 3'b001 << r_owner;
            r_err    <= 1'b0;
            r_gnt    <= 3'b000;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= DONE;
          end else if (r_tcnt == C_TCNT_LAST) begin
            r_rdata  <= 8'h00;
            r_done   <= 3'b001 << r_owner;
            r_err    <= 1'b1;
            r_gnt    <= 3'b000;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 3'b000;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign busy      = r_busy;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model predicts the winner, starvation count, completion edge,
//               err and rdata for each access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW           = 8;
  localparam int TIMEOUT      = 16;
  localparam int STARVE_LIMIT = 4;

  logic            clk;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [23:0]     wdata;
  logic [2:0]      gnt;
  logic [2:0]      done;
  logic [7:0]      rdata;
  logic            err;
  logic            busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_wdata;
  logic            mem_ready;
  logic [7:0]      mem_rdata;

  int checks;
  int errors;
  int m_starve;

  mem_port_arbiter #(
    .AW           (AW),
    .TIMEOUT      (TIMEOUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Who should win: starved fetch first, otherwise stack > operand > fetch
  function automatic int model_pick(input logic [2:0] rq);
    if (m_starve == STARVE_LIMIT && rq[0]) return 0;
    if (rq[2]) return 2;
    if (rq[1]) return 1;
    return 0;
  endfunction

  task automatic apply_reset();
    reset     = 1'b0;
    req       = 3'b000;
    we        = 3'b000;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    m_starve  = 0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // One complete access; k = edge (after grant) on which mem_ready is given
  task automatic do_access(input logic [2:0] rq, input logic [2:0] w,
                           input logic [23:0] a, input logic [23:0] d,
                           input int k, output logic [2:0] g_obs);
    int         wi;
    int         end_edge;
    logic       exp_err;
    logic [2:0] exp_gnt;
    logic [7:0] rd;
    logic [7:0] exp_rd;
    bit         finished;
    wi       = model_pick(rq);
    exp_gnt  = 3'b000;
    exp_gnt[wi] = 1'b1;
    end_edge = (k <= TIMEOUT) ? k : TIMEOUT;
    exp_err  = (k > TIMEOUT);
    rd       = 8'h00;
    finished = 1'b0;
    req = rq; we = w; addr = a; wdata = d; mem_ready = 1'b0;
    step();
    g_obs = gnt;
    checks++;
    if ({gnt, mem_en, mem_we, mem_addr, mem_wdata, busy, done} !==
        {exp_gnt, 1'b1, w[wi], a[wi*8 +: 8], d[wi*8 +: 8], 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL grant: gnt=%b en=%b we=%b addr=%h wd=%h busy=%b done=%b required gnt=%b en=1 we=%b addr=%h wd=%h busy=1 done=000",
               gnt, mem_en, mem_we, mem_addr, mem_wdata, busy, done,
               exp_gnt, w[wi], a[wi*8 +: 8], d[wi*8 +: 8]);
    end
    if (wi == 0) m_starve = 0;
    else if (rq[0]) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    for (int i = 1; i <= end_edge && !finished; i++) begin
      mem_ready = (i == k);
      mem_rdata = 8'($urandom);
      if (i == k) rd = mem_rdata;
      step();
      mem_ready = 1'b0;
      if (i < end_edge) begin
        if ({gnt, mem_en, done} !== {exp_gnt, 1'b1, 3'b000}) begin
          checks++;
          errors++;
          finished = 1'b1;
          $display("FAIL hold edge %0d: gnt=%b en=%b done=%b required gnt=%b en=1 done=000",
                   i, gnt, mem_en, done, exp_gnt);
        end
      end else begin
        exp_rd = exp_err ? 8'h00 : rd;
        checks++;
        if ({done, err, rdata, gnt, mem_en, busy} !==
            {exp_gnt, exp_err, exp_rd, 3'b000, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL done edge %0d: done=%b err=%b rdata=%h gnt=%b en=%b busy=%b required done=%b err=%b rdata=%h gnt=000 en=0 busy=1",
                   i, done, err, rdata, gnt, mem_en, busy, exp_gnt, exp_err, exp_rd);
        end
      end
    end
    // Owner drops its request on the edge that samples done
    req = rq & ~exp_gnt;
    step();
    checks++;
    if ({done, err, busy, mem_en, gnt} !== 9'b0) begin
      errors++;
      $display("FAIL idle gap: done=%b err=%b busy=%b en=%b gnt=%b required all 0",
               done, err, busy, mem_en, gnt);
    end
  endtask

  task automatic test_reset();
    logic [2:0] g;
    reset = 1'b0;
    req = 3'b000; we = 3'b000; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = 8'h00;
    m_starve = 0;
    #2;
    checks++;
    if ({gnt, done, rdata, err, busy, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs: gnt=%b done=%b rdata=%h err=%b busy=%b en=%b required all 0",
               gnt, done, rdata, err, busy, mem_en);
    end
    step();
    reset = 1'b1;
    // No request in IDLE keeps everything quiet
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt, done, busy, mem_en} !== 8'b0) begin
        errors++;
        $display("FAIL idle no req: gnt=%b done=%b busy=%b en=%b required 0",
                 gnt, done, busy, mem_en);
      end
    end
    g = 3'b000;
  endtask

  task automatic test_fetch_read();
    logic [2:0] g;
    apply_reset();
    // Fetch read of 0x10, memory answers one cycle after mem_en
    addr = 24'h000010;
    req = 3'b001; we = 3'b000; mem_ready = 1'b0;
    step();
    checks++;
    if ({gnt, mem_en, mem_we, mem_addr} !== {3'b001, 1'b1, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL fetch grant: gnt=%b en=%b we=%b addr=%h required 001 1 0 10",
               gnt, mem_en, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 8'hA5;
    step();
    mem_ready = 1'b0; req = 3'b000;
    checks++;
    if ({done, rdata, err} !== {3'b001, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL fetch done: done=%b rdata=%h err=%b required 001 a5 0",
               done, rdata, err);
    end
    step();
    checks++;
    if (done !== 3'b000) begin
      errors++;
      $display("FAIL fetch done width: done=%b required 000", done);
    end
    g = 3'b000;
  endtask

  task automatic test_stack_write();
    logic [2:0] g;
    apply_reset();
    do_access(3'b100, 3'b100, 24'hFE0000, 24'h3C0000, 2, g);
    checks++;
    if (g !== 3'b100) begin
      errors++;
      $display("FAIL stack write owner: gnt=%b required 100", g);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] g;
    logic [2:0] rq;
    logic [2:0] expect_seq [3];
    expect_seq[0] = 3'b100; expect_seq[1] = 3'b010; expect_seq[2] = 3'b001;
    apply_reset();
    rq = 3'b111;
    for (int i = 0; i < 3; i++) begin
      do_access(rq, 3'b000, 24'h332211, 24'hCCBBAA, 1, g);
      checks++;
      if (g !== expect_seq[i]) begin
        errors++;
        $display("FAIL simultaneous order %0d: gnt=%b required %b", i, g, expect_seq[i]);
      end
      rq = rq & ~g;
    end
    req = 3'b000;
  endtask

  task automatic test_starvation();
    logic [2:0] g;
    apply_reset();
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      do_access(3'b101, 3'b000, 24'h200010, 24'h0, 1, g);
      checks++;
      if (g !== 3'b100) begin
        errors++;
        $display("FAIL starve stack win %0d: gnt=%b required 100", i, g);
      end
    end
    do_access(3'b101, 3'b000, 24'h200010, 24'h0, 1, g);
    checks++;
    if (g !== 3'b001) begin
      errors++;
      $display("FAIL starve override: gnt=%b required 001", g);
    end
    // Counter cleared: stack wins again
    do_access(3'b101, 3'b000, 24'h200010, 24'h0, 1, g);
    checks++;
    if (g !== 3'b100) begin
      errors++;
      $display("FAIL starve cleared: gnt=%b required 100", g);
    end
    req = 3'b000;
  endtask

  task automatic test_timeout();
    logic [2:0] g;
    apply_reset();
    do_access(3'b010, 3'b000, 24'h004400, 24'h0, TIMEOUT + 5, g);
    do_access(3'b010, 3'b000, 24'h004400, 24'h0, TIMEOUT, g);
    do_access(3'b001, 3'b001, 24'h000077, 24'h000099, TIMEOUT - 1, g);
    req = 3'b000;
  endtask

  task automatic test_reset_mid_access();
    logic [2:0] g;
    apply_reset();
    req = 3'b010; we = 3'b000; addr = 24'h005500; mem_ready = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_en, gnt, busy, done} !== 8'b0) begin
      errors++;
      $display("FAIL async reset: en=%b gnt=%b busy=%b done=%b required 0",
               mem_en, gnt, busy, done);
    end
    req = 3'b000;
    m_starve = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (done !== 3'b000) begin
        errors++;
        $display("FAIL reset no done: done=%b required 000", done);
      end
    end
    reset = 1'b1;
    step();
    do_access(3'b010, 3'b000, 24'h005500, 24'h0, 3, g);
    checks++;
    if (g !== 3'b010) begin
      errors++;
      $display("FAIL after reset access: gnt=%b required 010", g);
    end
    req = 3'b000;
  endtask

  task automatic test_random();
    logic [2:0] g;
    logic [2:0] rq;
    int         k;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      rq = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 9))
        0:       k = TIMEOUT + 1;
        1:       k = TIMEOUT;
        default: k = $urandom_range(1, 5);
      endcase
      do_access(rq, 3'($urandom), 24'($urandom), 24'($urandom), k, g);
      // Sometimes leave an idle cycle with no request
      if ($urandom_range(0, 3) == 0) begin
        req = 3'b000;
        step();
        checks++;
        if ({gnt, busy, mem_en} !== 5'b0) begin
          errors++;
          $display("FAIL random idle: gnt=%b busy=%b en=%b required 0", gnt, busy, mem_en);
        end
      end
    end
    req = 3'b000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_read();
    test_stack_write();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single byte-wide memory port between three requesters: instruction fetch (FETCH1–FETCH3 byte reads), operand access (MEMDIR/PC-relative reads) and stack (PUSH write / POP read).
- Sits between the control/datapath and the memory.
- Grants one requester at a time, holds the grant until the memory signals ready or a timeout fires, then pulses completion to the owner.
- Fixed priority with a fetch anti-starvation override.

Parameters:
AW, 8, memory address width in bits
TIMEOUT, 16, max ACCESS cycles before the access is aborted with err (must be ≥2)
STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch is forced to win

Ports:
clk  in  1  clock, all flops on rising edge
reset  in  1  asynchronous, active-low reset
req  in  3  request per requester: bit0 fetch, bit1 operand, bit2 stack
we  in  3  write enable per requester (1 = write)
addr  in  3*AW  packed addresses; requester i uses addr[i*AW +: AW]
wdata  in  24  packed write data; requester i uses wdata[i*8 +: 8]
gnt  out  3  one-hot grant, high for the whole owned access
done  out  3  one-cycle completion pulse to the owner
rdata  out  8  read data, valid while done is high
err  out  1  high with done when the access timed out
busy  out  1  high in ACCESS and DONE states
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  8  memory write data
mem_ready  in  1  memory completion; read data is valid on mem_rdata in the same cycle
mem_rdata  in  8  memory read data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; timeout counter, starve counter and owner all cleared.
- States: IDLE, ACCESS, DONE.
- IDLE, on the edge where req!=0:
  - Winner = fetch if starve_cnt==STARVE_LIMIT and req[0]=1; otherwise priority stack > operand > fetch.
  - Registers: owner, gnt[owner]=1, mem_en=1, mem_we/mem_addr/mem_wdata from the owner's lanes; timeout counter=0; state→ACCESS.
- Starve counter:
  - Increments on each IDLE arbitration where req[0]=1 and fetch loses; saturates at STARVE_LIMIT.
  - Clears when fetch is granted.
  - Unchanged when fetch is not requesting.
- ACCESS:
  - mem_en and the latched address/data are held stable. Requester inputs are not re-sampled; a req drop mid-access is ignored and the access still completes.
  - Edge with mem_ready=1: rdata=mem_rdata (writes: rdata=mem_rdata too, don't-care to the requester); done[owner]=1; err=0; gnt=0; mem_en=0; mem_we=0; state→DONE.
  - Edge with mem_ready=0 and counter==TIMEOUT-1: done[owner]=1; err=1; rdata=0; gnt=0; mem_en=0; state→DONE.
  - Otherwise the counter increments.
  - mem_ready and timeout on the same edge: mem_ready wins, err=0.
- DONE: one cycle; done and err return to 0 on exit; state→IDLE. This guarantees a one-cycle bus-idle gap between accesses.
- Latency:
  - req seen at edge N → gnt/mem_en high after N.
  - mem_ready sampled at edge N+k (k≥1) → done high for the cycle after N+k.
  - Minimum request-to-done is 2 edges.
- Requester contract:
  - Hold req/we/addr/wdata stable from request until done.
  - Deassert req on the edge that samples done=1.
  - A req still high in IDLE afterwards is treated as a new request.
- req==0 in IDLE: no state change, outputs stay 0.
- reset asserted mid-ACCESS: immediate return to IDLE with mem_en=0 and no done pulse.

Decomposition:
- Shared package (proc_pkg): requester index constants (REQ_FETCH=0, REQ_OPND=1, REQ_STACK=2); arbiter state enum (IDLE, ACCESS, DONE).
- Sub-module prio_sel: combinational 3-way fixed-priority select with force-fetch input; outputs a one-hot winner.
- Counters and FSM stay in the top module.

Test Plan:
- Single fetch read: req=3'b001, addr0=8'h10, mem_ready one cycle after mem_en with mem_rdata=8'hA5 → mem_addr=8'h10, mem_we=0, done=3'b001 for 1 cycle, rdata=8'hA5, err=0.
- Stack write: req=3'b100, we=3'b100, addr2=8'hFE, wdata2=8'h3C → mem_we=1, mem_wdata=8'h3C, mem_addr=8'hFE, done=3'b100.
- Simultaneous req=3'b111 → stack granted first, then operand, then fetch. Each grant is separated by a DONE cycle; gnt is always one-hot.
- Starvation: hold req[0]=1 while re-raising req[2] every IDLE, STARVE_LIMIT=4 → after 4 stack grants the fetch is granted despite req[2]=1; starve counter clears.
- Timeout: mem_ready held 0, TIMEOUT=16 → done pulses exactly 16 edges after mem_en rose, err=1, rdata=0; with mem_ready=1 on that same edge → err=0.
- Reset mid-ACCESS: drive reset=0 asynchronously while mem_en=1 → mem_en, gnt and busy drop without waiting for clk; no done pulse; a subsequent req is served normally.
